// File: rtl/e1000_tx_fetch_sched.sv
// e1000_tx_fetch_sched
//   Transmit-descriptor fetch scheduler. Tracks the host TX descriptor ring
//   (ring_len / tdh / tail), decides when the bus-master reads descriptors
//   into the on-chip cache (PTHRESH/HTHRESH prefetch rules), splits bursts at
//   the ring end, advances the head as descriptors are retired and raises
//   TXQE / TXD_LOW / consume-error event pulses.
//
//   Optional feature macro: E1000_TXD_LOW_EN
//     defined   -> lwthresh compare and txd_low generation compiled in
//     undefined -> txd_low tied 0, lwthresh unused
//
// Ports
//   clk, rst          bus clock, synchronous active-high reset
//   enable            TCTL.EN
//   ring_len          ring size in descriptors
//   tdt, tdt_wr       tail write (ignored when tdt >= ring_len)
//   tdh_in, tdh_wr    head write, honoured only while enable=0
//   pthresh, hthresh  prefetch / host thresholds
//   lwthresh          low threshold in units of 8 descriptors
//   fetch_valid/ready request handshake to the bus-master
//   fetch_idx, fetch_cnt  first index and length of the burst
//   fetch_done        whole accepted burst landed in the cache
//   desc_consume      datapath retired one descriptor
//   tdh, cache_level  current head, valid descriptors in the cache
//   txqe, txd_low, consume_err  one-cycle event pulses

module e1000_tx_fetch_sched #(
    parameter int unsigned CACHE_DEPTH = 16,
    parameter int unsigned MAX_BURST   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] ring_len,
    input  logic [15:0] tdt,
    input  logic        tdt_wr,
    input  logic [15:0] tdh_in,
    input  logic        tdh_wr,
    input  logic [5:0]  pthresh,
    input  logic [5:0]  hthresh,
    input  logic [6:0]  lwthresh,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [15:0] fetch_idx,
    output logic [6:0]  fetch_cnt,
    input  logic        fetch_done,
    input  logic        desc_consume,
    output logic [15:0] tdh,
    output logic [6:0]  cache_level,
    output logic        txqe,
    output logic        txd_low,
    output logic        consume_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] tail_q;
    logic [15:0] fptr;
    logic [6:0]  inflight;

    // Forward distance from b to a around a ring of len entries.
    function automatic logic [15:0] ring_dist(input logic [15:0] a,
                                              input logic [15:0] b,
                                              input logic [15:0] len);
        return (a >= b) ? (a - b) : (a + len - b);
    endfunction

    logic [15:0] unfetched;
    logic [15:0] free_slots;
    logic [15:0] to_end;
    logic [15:0] burst_len;
    logic        thresh_ok;
    logic        start_fetch;
    logic        consume_ok;
    logic [15:0] tdh_inc;
    logic [15:0] tdh_nxt;
    logic [6:0]  done_add;
    logic [6:0]  level_nxt;
    logic        flush;
    logic [16:0] fetch_end;
    logic [15:0] fptr_adv;

    always_comb begin
        unfetched  = ring_dist(tail_q, fptr, ring_len);
        free_slots = 16'(CACHE_DEPTH) - {9'd0, cache_level} - {9'd0, inflight};
        to_end     = ring_len - fptr;

        burst_len = unfetched;
        if (free_slots < burst_len)
            burst_len = free_slots;
        if (to_end < burst_len)
            burst_len = to_end;
        if (16'(MAX_BURST) < burst_len)
            burst_len = 16'(MAX_BURST);

        // pthresh=0 disables the cache-level gate; hthresh=0 is trivially met.
        thresh_ok = ((pthresh == 6'd0) || (cache_level < {1'b0, pthresh})) &&
                    (unfetched >= {10'd0, hthresh});

        start_fetch = (state == ST_IDLE) && enable &&
                      (unfetched != 16'd0) && (free_slots != 16'd0) &&
                      ((cache_level == 7'd0) || thresh_ok);

        consume_ok = desc_consume && (cache_level != 7'd0);
        tdh_inc    = tdh + 16'd1;
        tdh_nxt    = tdh;
        if (consume_ok)
            tdh_nxt = (tdh_inc == ring_len) ? 16'd0 : tdh_inc;

        done_add  = ((state == ST_WAIT) && fetch_done) ? inflight : 7'd0;
        level_nxt = cache_level + done_add - {6'd0, consume_ok};

        flush = (state == ST_IDLE) && !enable;

        fetch_end = {1'b0, fptr} + {10'd0, fetch_cnt};
        fptr_adv  = (fetch_end == {1'b0, ring_len}) ? 16'd0 : fetch_end[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            tail_q      <= '0;
            tdh         <= '0;
            fptr        <= '0;
            cache_level <= '0;
            inflight    <= '0;
            fetch_valid <= 1'b0;
            fetch_idx   <= '0;
            fetch_cnt   <= '0;
            txqe        <= 1'b0;
            consume_err <= 1'b0;
        end else begin
            consume_err <= desc_consume && (cache_level == 7'd0);
            txqe        <= consume_ok && (tdh_nxt == tail_q);

            if (tdt_wr && (tdt < ring_len))
                tail_q <= tdt;

            tdh         <= tdh_nxt;
            cache_level <= level_nxt;

            case (state)
                ST_IDLE: begin
                    if (start_fetch) begin
                        fetch_idx   <= fptr;
                        fetch_cnt   <= burst_len[6:0];
                        fetch_valid <= 1'b1;
                        state       <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (fetch_ready) begin
                        inflight    <= fetch_cnt;
                        fptr        <= fptr_adv;
                        fetch_valid <= 1'b0;
                        state       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (fetch_done) begin
                        inflight <= '0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    fetch_valid <= 1'b0;
                end
            endcase

            // Disabled and idle: drop cached descriptors and refetch from head.
            if (flush) begin
                cache_level <= '0;
                fptr        <= tdh_nxt;
            end

            if (tdh_wr && !enable) begin
                tdh         <= tdh_in;
                fptr        <= tdh_in;
                cache_level <= '0;
            end
        end
    end

`ifdef E1000_TXD_LOW_EN
    logic [15:0] low_mark;
    logic [15:0] pend_old;
    logic [15:0] pend_new;

    always_comb begin
        low_mark = {6'd0, lwthresh, 3'b000};
        pend_old = ring_dist(tail_q, tdh, ring_len);
        pend_new = ring_dist(tail_q, tdh_nxt, ring_len);
    end

    always_ff @(posedge clk) begin
        if (rst)
            txd_low <= 1'b0;
        else
            txd_low <= consume_ok && (lwthresh != 7'd0) &&
                       (pend_new < low_mark) && (pend_old >= low_mark);
    end
`else
    logic unused_lwthresh;
    assign unused_lwthresh = ^lwthresh;
    assign txd_low = 1'b0;
`endif

endmodule

// File: doc/e1000_tx_fetch_sched.md
# e1000_tx_fetch_sched

Transmit-descriptor fetch scheduler for the E1000-compatible NIC transmit path. It tracks the host descriptor ring (TDLEN/TDH/TDT) and decides when, where and how many descriptors the PCI bus-master reads into the on-chip descriptor cache, applying PTHRESH/HTHRESH prefetch rules. It splits bursts at the ring end. It advances TDH as the transmit datapath retires descriptors and raises TXQE/TXD_LOW events for the interrupt block.

## Interface
- CACHE_DEPTH, 16, on-chip descriptor cache entries (power of 2, 8..64)
- MAX_BURST, 8, maximum descriptors per fetch request (≤ CACHE_DEPTH)
- clk  in  1  bus clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- enable  in  1  TCTL.EN
- ring_len  in  16  ring size in descriptors (TDLEN/16); multiple of 8, ≥ 8
- tdt  in  16  tail value; sampled when tdt_wr=1
- tdt_wr  in  1  tail write strobe
- tdh_in  in  16  head value; sampled when tdh_wr=1
- tdh_wr  in  1  head write strobe; honoured only while enable=0
- pthresh  in  6  prefetch threshold (TXDCTL.PTHRESH)
- hthresh  in  6  host threshold (TXDCTL.HTHRESH)
- lwthresh  in  7  low threshold, in units of 8 descriptors
- fetch_valid  out  1  fetch request pending
- fetch_ready  in  1  bus-master accepts request
- fetch_idx  out  16  first ring index of burst
- fetch_cnt  out  7  descriptors in burst (1..MAX_BURST)
- fetch_done  in  1  one-cycle pulse: whole accepted burst has landed in cache
- desc_consume  in  1  one-cycle pulse: datapath retired one descriptor
- tdh  out  16  current head
- cache_level  out  7  valid descriptors held in cache
- txqe  out  1  one-cycle pulse: ring became empty
- txd_low  out  1  one-cycle pulse: pending descriptors fell below lwthresh*8
- consume_err  out  1  one-cycle pulse: desc_consume with cache_level=0

## Operation
- Registers: tail_q, tdh, fptr (next index to fetch), cache_level, inflight (0..MAX_BURST), state.
- Ring distance d(a,b) = a≥b ? a−b : a+ring_len−b, 16-bit.
- unfetched = d(tail_q, fptr); free = CACHE_DEPTH − cache_level − inflight; to_end = ring_len − fptr.
- States: IDLE, REQ, WAIT.
- IDLE → REQ when enable=1, unfetched>0, free>0, and either cache_level=0 or (cache_level<pthresh and unfetched≥hthresh). pthresh=0 means always prefetch. hthresh=0 means no host threshold.
- On that transition, latch fetch_idx=fptr and fetch_cnt=min(unfetched, free, to_end, MAX_BURST).
- REQ: fetch_valid=1; fetch_idx and fetch_cnt are held stable. On fetch_valid&fetch_ready: inflight←fetch_cnt; fptr←(fptr+fetch_cnt)=ring_len ? 0 : fptr+fetch_cnt; go to WAIT.
- WAIT: on fetch_done, cache_level += inflight, inflight←0, go to IDLE. Only one request is ever outstanding.
- desc_consume with cache_level>0: tdh←tdh+1 wrapping to 0 at ring_len; cache_level −1.
- desc_consume with cache_level=0: ignored; consume_err pulses.
- Same-cycle fetch_done and desc_consume: cache_level += inflight−1.
- txqe pulses in the cycle after a consume that makes tdh==tail_q.
- txd_low pulses in the cycle after a consume where pending = d(tail_q, new tdh) < lwthresh*8 and the previous pending ≥ lwthresh*8. lwthresh=0 disables it.
- tdt_wr with tdt ≥ ring_len is ignored. A same-cycle tdt_wr and fetch decision uses the old tail; the new tail is seen the next cycle.
- tdh_wr (enable=0): tdh←tdh_in, fptr←tdh_in, cache_level←0.
- enable falling: no new request is issued. A REQ or WAIT in progress completes normally. Once in IDLE with enable=0, cache_level←0 and fptr←tdh (cache flush).

## Timing
- Reset: all registers 0, state IDLE, fetch_valid=0, fetch_idx=0, fetch_cnt=0, tdh=0, cache_level=0, txqe=txd_low=consume_err=0.
- fetch_valid rises 1 cycle after the IDLE condition holds.
- After fetch_done, at least 1 IDLE cycle passes before the next fetch_valid.
- tdh and cache_level update the cycle after desc_consume.
- Event pulses (txqe, txd_low, consume_err) are exactly 1 cycle wide.
- rst mid-burst: immediate return to reset state. fetch_done arriving later in IDLE is ignored.

## Configuration
- E1000_TXD_LOW_EN defined: lwthresh comparison and txd_low generation are compiled in.
- E1000_TXD_LOW_EN undefined: txd_low is tied 0, lwthresh is unused, and the pending-count compare logic is removed.

## Test plan
- ring_len=8, pthresh=0, hthresh=0, tdt←4 → one request idx=0 cnt=4; fetch_done → cache_level=4; 4 consumes → tdh=4, txqe pulses once.
- ring_len=16, fptr=tdh=12, tdt←4 → two bursts: idx=12 cnt=4, then idx=0 cnt=4; fptr ends at 4.
- CACHE_DEPTH=16, ring_len=65528, tdt←40, no consumes → bursts of 8 until cache_level=16; no further fetch_valid until a consume frees space.
- pthresh=8, hthresh=4, cache_level=10 with 20 unfetched → no request. After consumes reduce cache_level to 7 → request cnt=min(20, 9, 8)=8.
- lwthresh=2, ring_len=64, tdt=20, tdh=3 → txd_low pulses on the consume taking pending from 16 to 15, and only then (macro defined). With the macro undefined, txd_low stays 0.
- Random fetch_ready stalls (fetch_idx/fetch_cnt stable while valid), same-cycle fetch_done+consume, consume at cache_level=0 → consume_err, rst during WAIT → all outputs back to 0.
